// File: rtl/adaptive_filter_pkg.sv
// Shared types and defaults for the adaptive filter and its
// mode-switch sequencer.
package adaptive_filter_pkg;

   localparam int WORDLENGTH = 14;

   localparam logic MODE_DIFF   = 1'b0;
   localparam logic MODE_INTEGR = 1'b1;

   localparam int MODE_CTRL_PIPE_LAT   = 2;
   localparam int MODE_CTRL_WARMUP_LEN = 9;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      CLEAR
   } mode_ctrl_state_t;

endpackage

// File: rtl/adaptive_filter_dcnt.sv
// Loadable saturating down-counter with a zero flag.
// Load has priority over decrement; decrement stops at zero.
module adaptive_filter_dcnt
   import adaptive_filter_pkg::*;
#(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: load wins, otherwise saturating decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adaptive_filter_mode_ctrl.sv
// Mode-switch sequencer: stalls, drains and resets the filter on a
// mode change, then hides the filter's start-up transient.
module adaptive_filter_mode_ctrl
   import adaptive_filter_pkg::*;
#(
   parameter int DATA_W     = WORDLENGTH,
   parameter int PIPE_LAT   = MODE_CTRL_PIPE_LAT,
   parameter int WARMUP_LEN = MODE_CTRL_WARMUP_LEN
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              mode_req,
   input  logic              mode_req_valid,
   output logic              mode_req_ready,
   output logic              mode,
   output logic              busy,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic              f_srst,
   output logic              f_ctrl,
   output logic [DATA_W-1:0] f_tdata,
   output logic              f_tvalid,
   input  logic [DATA_W-1:0] f_m_tdata,
   input  logic              f_m_tvalid,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid
);

   localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
   localparam int WARM_W  = $clog2(WARMUP_LEN + 1);

   // DRAIN lasts PIPE_LAT cycles and leaves when the counter is zero,
   // so it is loaded one short of PIPE_LAT.
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);
   localparam logic [WARM_W-1:0]  WARM_LOAD  = WARM_W'(WARMUP_LEN);

   mode_ctrl_state_t state_q;
   logic             mode_q;
   logic             req_q;
   logic             m_tvalid_q;
   logic [DATA_W-1:0] m_tdata_q;

   logic in_run;
   logic switch_acc;
   logic drain_zero;
   logic warm_zero;
   logic fwd;

   assign in_run     = (state_q == RUN);
   assign switch_acc = mode_req_valid & mode_req_ready
                     & (mode_req != mode_q);
   assign fwd        = f_m_tvalid & warm_zero;

   adaptive_filter_dcnt #(
      .W       (DRAIN_W),
      .RST_VAL ('0)
   ) u_drain_cnt (
      .clk        (clk),
      .srst       (srst),
      .load_i     (switch_acc),
      .load_val_i (DRAIN_LOAD),
      .dec_i      (state_q == DRAIN),
      .zero_o     (drain_zero)
   );

   adaptive_filter_dcnt #(
      .W       (WARM_W),
      .RST_VAL (WARM_LOAD)
   ) u_warm_cnt (
      .clk        (clk),
      .srst       (srst),
      .load_i     (state_q == CLEAR),
      .load_val_i (WARM_LOAD),
      .dec_i      (f_m_tvalid),
      .zero_o     (warm_zero)
   );

   // sequencer: RUN -> DRAIN -> CLEAR -> RUN, mode swaps leaving CLEAR
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= RUN;
         mode_q  <= MODE_DIFF;
         req_q   <= MODE_DIFF;
      end else begin
         unique case (state_q)
            RUN: begin
               if (switch_acc) begin
                  req_q   <= mode_req;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_zero) begin
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
               mode_q  <= req_q;
               state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // output stage: forward filter samples once warmup is over
   always_ff @(posedge clk) begin
      if (srst) begin
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
      end else begin
         m_tvalid_q <= fwd;
         if (fwd) begin
            m_tdata_q <= f_m_tdata;
         end
      end
   end

   assign mode_req_ready = in_run & warm_zero;
   assign busy           = ~in_run | ~warm_zero;
   assign s_tready       = in_run;
   assign f_tvalid       = s_tvalid & in_run;
   assign f_tdata        = s_tdata;
   assign f_srst         = srst | (state_q == CLEAR);
   assign f_ctrl         = mode_q;
   assign mode           = mode_q;
   assign m_tvalid       = m_tvalid_q;
   assign m_tdata        = m_tdata_q;

endmodule

// File: tb/tb_adaptive_filter_mode_ctrl.sv
// Randomized bench for adaptive_filter_mode_ctrl with a stub filter
// and a cycle-level reference model of the switch sequence.
module tb_adaptive_filter_mode_ctrl;

   localparam int DW = 14;
   localparam int PL = 2;
   localparam int WU = 9;

   logic          clk = 1'b0;
   logic          srst;
   logic          mode_req;
   logic          mode_req_valid;
   logic          mode_req_ready;
   logic          mode;
   logic          busy;
   logic [DW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic          f_srst;
   logic          f_ctrl;
   logic [DW-1:0] f_tdata;
   logic          f_tvalid;
   logic [DW-1:0] f_m_tdata;
   logic          f_m_tvalid;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;

   always #5 clk = ~clk;

   adaptive_filter_mode_ctrl #(
      .DATA_W     (DW),
      .PIPE_LAT   (PL),
      .WARMUP_LEN (WU)
   ) dut (
      .clk            (clk),
      .srst           (srst),
      .mode_req       (mode_req),
      .mode_req_valid (mode_req_valid),
      .mode_req_ready (mode_req_ready),
      .mode           (mode),
      .busy           (busy),
      .s_tdata        (s_tdata),
      .s_tvalid       (s_tvalid),
      .s_tready       (s_tready),
      .f_srst         (f_srst),
      .f_ctrl         (f_ctrl),
      .f_tdata        (f_tdata),
      .f_tvalid       (f_tvalid),
      .f_m_tdata      (f_m_tdata),
      .f_m_tvalid     (f_m_tvalid),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid)
   );

   // stub filter: two-stage delay, tags data with ctrl, cleared by srst
   logic          s1_v, s2_v;
   logic [DW-1:0] s1_d, s2_d;

   always_ff @(posedge clk) begin
      if (f_srst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= f_tvalid;
         s1_d <= f_tdata + DW'(f_ctrl);
         s2_v <= s1_v;
         s2_d <= s1_d;
      end
   end

   assign f_m_tvalid = s2_v;
   assign f_m_tdata  = s2_d;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h",
                  tag, cyc, obs, exp);
      end
   endtask

   // reference model: ph = cycles since a switch was accepted
   int            ph;
   int            warm;
   logic          mode_m;
   logic          req_m;
   logic          mv_m;
   logic [DW-1:0] md_m;
   logic [DW-1:0] q[$];

   logic          e_run, e_rdy, e_fsrst, e_fv;
   logic [DW-1:0] popped;

   task automatic model_reset();
      ph     = 0;
      warm   = WU;
      mode_m = 1'b0;
      req_m  = 1'b0;
      mv_m   = 1'b0;
      md_m   = '0;
      q.delete();
   endtask

   task automatic check_and_step();
      e_run   = (ph == 0);
      e_rdy   = e_run && (warm == 0);
      e_fsrst = srst || (ph == PL + 1);
      e_fv    = s_tvalid && e_run;

      chk("s_tready", 32'(s_tready), 32'(e_run));
      chk("req_ready", 32'(mode_req_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(!e_rdy));
      chk("f_srst", 32'(f_srst), 32'(e_fsrst));
      chk("f_ctrl", 32'(f_ctrl), 32'(mode_m));
      chk("mode", 32'(mode), 32'(mode_m));
      chk("f_tvalid", 32'(f_tvalid), 32'(e_fv));
      if (e_fv) chk("f_tdata", 32'(f_tdata), 32'(s_tdata));
      chk("m_tvalid", 32'(m_tvalid), 32'(mv_m));
      chk("m_tdata", 32'(m_tdata), 32'(md_m));

      if (srst) begin
         model_reset();
         return;
      end
      mv_m = 1'b0;
      if (f_m_tvalid && q.size() != 0) begin
         popped = q.pop_front();
         if (warm > 0) begin
            warm--;
         end else begin
            mv_m = 1'b1;
            md_m = popped;
         end
      end
      if (ph == PL + 1) begin
         q.delete();
         warm   = WU;
         mode_m = req_m;
         ph     = 0;
      end else if (ph > 0) begin
         ph++;
      end else begin
         if (e_fv) q.push_back(s_tdata + DW'(mode_m));
         if (mode_req_valid && e_rdy && mode_req != mode_m) begin
            req_m = mode_req;
            ph    = 1;
         end
      end
   endtask

   initial begin
      srst           = 1'b1;
      mode_req       = 1'b0;
      mode_req_valid = 1'b0;
      s_tvalid       = 1'b0;
      s_tdata        = '0;
      model_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 3200; i++) begin
         @(negedge clk);
         cyc = i;
         if (i < 2) begin
            srst           = 1'b1;
            s_tvalid       = 1'b0;
            mode_req_valid = 1'b0;
         end else if (i < 22) begin
            srst     = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = DW'(100);
         end else if (i < 30) begin
            s_tvalid = 1'b0;
         end else if (i < 32) begin
            mode_req_valid = 1'b1;
            mode_req       = 1'b1;
            s_tvalid       = 1'b1;
            s_tdata        = DW'(64);
         end else if (i == 32) begin
            mode_req_valid = 1'b0;
            srst           = 1'b1;
         end else if (i < 40) begin
            srst     = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = DW'(64);
         end else begin
            srst           = ($urandom_range(0, 299) == 0);
            s_tvalid       = ($urandom_range(0, 3) != 0);
            s_tdata        = DW'($urandom);
            mode_req       = 1'($urandom);
            mode_req_valid = ($urandom_range(0, 5) == 0);
         end
         #1;
         check_and_step();
      end
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
